// File: rtl/predictor_update_sched.sv
// Merges branch-resolution reports from two commit sources into a small in-order
// FIFO and issues them one per cycle to the predictor's single update port.
module predictor_update_sched #(
    parameter int DEPTH       = 4,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        a_valid,
    input  logic [31:0] a_pc,
    input  logic        a_taken,
    input  logic        a_pred,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_pc,
    input  logic        b_taken,
    input  logic        b_pred,
    output logic        b_ready,
    output logic        update,
    output logic [31:0] update_pc,
    output logic        update_result,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int CW = DEPTH_WIDTH + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] ROOM_FOR2 = CW'(DEPTH - 2);

    // Entry layout: {pc[31:0], taken, pred}
    logic [33:0]            mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0]          count_reg, count_next;
    logic                   push_a, push_b, pop;
    logic [DEPTH_WIDTH-1:0] wptr_b;
    logic [33:0]            head;

    // Ready depends only on the occupancy at the start of the cycle; a
    // same-cycle pop does not free a slot for the incoming reports.
    assign a_ready = rdy & (count_reg < FULL);
    assign b_ready = rdy & (a_valid ? (count_reg <= ROOM_FOR2) : (count_reg < FULL));

    assign push_a = a_valid & a_ready;
    assign push_b = b_valid & b_ready;
    assign pop    = rdy & (count_reg != '0);
    assign wptr_b = wptr_reg + DEPTH_WIDTH'(push_a);
    assign head   = mem[rptr_reg];

    always_comb begin
        count_next = count_reg + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    // Storage is never reset: entries beyond count are never issued.
    always_ff @(posedge clk) begin
        if (push_a) mem[wptr_reg] <= {a_pc, a_taken, a_pred};
        if (push_b) mem[wptr_b]   <= {b_pc, b_taken, b_pred};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            update        <= 1'b0;
            update_pc     <= '0;
            update_result <= 1'b0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
        end else if (rdy) begin
            wptr_reg  <= wptr_b + DEPTH_WIDTH'(push_b);
            count_reg <= count_next;
            if (pop) begin
                rptr_reg      <= rptr_reg + 1'b1;
                update        <= 1'b1;
                update_pc     <= head[33:2];
                update_result <= head[1];
                branch_cnt    <= branch_cnt + 32'd1;
                if (head[1] != head[0]) mispred_cnt <= mispred_cnt + 32'd1;
            end else begin
                update <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_predictor_update_sched.sv
// Scoreboard bench: accepted reports are queued in a reference model and
// compared against the predictor update port as they are issued.
module tb_predictor_update_sched;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        a_valid, a_taken, a_pred, b_valid, b_taken, b_pred;
    logic [31:0] a_pc, b_pc;
    logic        a_ready, b_ready, update, update_result;
    logic [31:0] update_pc, branch_cnt, mispred_cnt;

    predictor_update_sched #(.DEPTH(4), .DEPTH_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .a_valid(a_valid), .a_pc(a_pc), .a_taken(a_taken), .a_pred(a_pred), .a_ready(a_ready),
        .b_valid(b_valid), .b_pc(b_pc), .b_taken(b_taken), .b_pred(b_pred), .b_ready(b_ready),
        .update(update), .update_pc(update_pc), .update_result(update_result),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        pred;
    } rep_t;

    rep_t        sb_q[$];
    int          m_count;
    logic        m_update, m_result;
    logic [31:0] m_pc, m_branch, m_mis;
    int          passed = 0;
    int          total  = 0;
    int          accepted_n, issued_n;
    logic        b_drop_seen;

    // One clock of stimulus: readies are checked before the edge against the
    // model's occupancy, outputs are checked after the edge.
    task automatic cycle(input logic av, input logic [31:0] apc, input logic at, input logic ap,
                         input logic bv, input logic [31:0] bpc, input logic bt, input logic bp,
                         input logic r);
        logic exp_ar, exp_br, pa, pb;
        rep_t e;
        @(negedge clk);
        rst = 1'b0; rdy = r;
        a_valid = av; a_pc = apc; a_taken = at; a_pred = ap;
        b_valid = bv; b_pc = bpc; b_taken = bt; b_pred = bp;
        #1;
        exp_ar = r && (m_count < 4);
        exp_br = r && (av ? (m_count <= 2) : (m_count <= 3));
        total++;
        if (a_ready !== exp_ar) $display("FAIL a_ready: got %b expected %b", a_ready, exp_ar);
        else passed++;
        total++;
        if (b_ready !== exp_br) $display("FAIL b_ready: got %b expected %b", b_ready, exp_br);
        else passed++;
        if (av && !exp_br) b_drop_seen = 1'b1;
        pa = av && exp_ar;
        pb = bv && exp_br;
        @(posedge clk);
        if (r) begin
            if (m_count != 0) begin
                e = sb_q.pop_front();
                m_update = 1'b1; m_pc = e.pc; m_result = e.taken;
                m_branch++;
                if (e.taken != e.pred) m_mis++;
                m_count--;
            end else begin
                m_update = 1'b0;
            end
            if (pa) begin sb_q.push_back({apc, at, ap}); m_count++; accepted_n++; end
            if (pb) begin sb_q.push_back({bpc, bt, bp}); m_count++; accepted_n++; end
        end
        #1;
        if (update === 1'b1 && r) issued_n++;
        total++;
        if (update !== m_update || (m_update && (update_pc !== m_pc || update_result !== m_result)))
            $display("FAIL update_port: got upd=%b pc=%h res=%b expected upd=%b pc=%h res=%b",
                     update, update_pc, update_result, m_update, m_pc, m_result);
        else passed++;
        total++;
        if (branch_cnt !== m_branch || mispred_cnt !== m_mis)
            $display("FAIL counters: got br=%0d mis=%0d expected br=%0d mis=%0d",
                     branch_cnt, mispred_cnt, m_branch, m_mis);
        else passed++;
        $display("cyc rdy=%b a=%b/%b b=%b/%b upd=%b pc=%h res=%b br=%0d mis=%0d occ=%0d",
                 r, av, exp_ar, bv, exp_br, update, update_pc, update_result,
                 branch_cnt, mispred_cnt, m_count);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, r);
    endtask

    // Reset applied with both sources still offering reports: reset must win.
    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1;
        a_valid = 1'b1; a_pc = 32'hDEAD_0000; a_taken = 1'b1; a_pred = 1'b0;
        b_valid = 1'b1; b_pc = 32'hDEAD_0004; b_taken = 1'b0; b_pred = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        m_count = 0; m_update = 1'b0; m_pc = '0; m_result = 1'b0; m_branch = '0; m_mis = '0;
        total++;
        if (update !== 1'b0 || update_pc !== 32'h0 || update_result !== 1'b0)
            $display("FAIL reset_update: got upd=%b pc=%h res=%b expected 0/0/0",
                     update, update_pc, update_result);
        else passed++;
        total++;
        if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0)
            $display("FAIL reset_counters: got br=%0d mis=%0d expected 0/0", branch_cnt, mispred_cnt);
        else passed++;
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1)
            $display("FAIL reset_empty: got a_ready=%b b_ready=%b expected 1/1", a_ready, b_ready);
        else passed++;
        $display("reset upd=%b pc=%h br=%0d mis=%0d", update, update_pc, branch_cnt, mispred_cnt);
    endtask

    task automatic test_single;
        test_reset();
        cycle(1, 32'h1004, 1, 0, 0, 0, 0, 0, 1);
        total++;
        if (update !== 1'b0) $display("FAIL single_no_bypass: got upd=%b expected 0", update);
        else passed++;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (update !== 1'b1 || update_pc !== 32'h1004 || update_result !== 1'b1)
            $display("FAIL single_issue: got upd=%b pc=%h res=%b expected 1/00001004/1",
                     update, update_pc, update_result);
        else passed++;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (update !== 1'b0 || branch_cnt !== 32'd1 || mispred_cnt !== 32'd1)
            $display("FAIL single_done: got upd=%b br=%0d mis=%0d expected 0/1/1",
                     update, branch_cnt, mispred_cnt);
        else passed++;
    endtask

    task automatic test_dual_order;
        test_reset();
        cycle(1, 32'h100, 0, 0, 1, 32'h200, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (update_pc !== 32'h100) $display("FAIL dual_first: got pc=%h expected 00000100", update_pc);
        else passed++;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (update_pc !== 32'h200) $display("FAIL dual_second: got pc=%h expected 00000200", update_pc);
        else passed++;
        idle(1, 1);
        total++;
        if (branch_cnt !== 32'd2 || mispred_cnt !== 32'd0)
            $display("FAIL dual_counts: got br=%0d mis=%0d expected 2/0", branch_cnt, mispred_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back;
        test_reset();
        accepted_n = 0; issued_n = 0; b_drop_seen = 1'b0;
        for (int i = 0; i < 10; i++)
            cycle(1, 32'hA000 + 32'(i * 8), i[0], 0, 1, 32'hB000 + 32'(i * 8), 1, i[1], 1);
        idle(6, 1);
        total++;
        if (b_drop_seen !== 1'b1) $display("FAIL bp_b_ready_drop: got %b expected 1", b_drop_seen);
        else passed++;
        total++;
        if (issued_n != accepted_n || sb_q.size() != 0)
            $display("FAIL bp_drain: got issued=%0d expected accepted=%0d (left %0d)",
                     issued_n, accepted_n, sb_q.size());
        else passed++;
    endtask

    task automatic test_stall;
        test_reset();
        cycle(1, 32'h40, 1, 1, 1, 32'h44, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 32'h48, 0, 0, 1, 32'h4C, 0, 0, 0);
        total++;
        if (update !== 1'b1 || update_pc !== 32'h40 || branch_cnt !== 32'd1)
            $display("FAIL stall_hold: got upd=%b pc=%h br=%0d expected 1/00000040/1",
                     update, update_pc, branch_cnt);
        else passed++;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (update !== 1'b1 || update_pc !== 32'h44)
            $display("FAIL stall_next: got upd=%b pc=%h expected 1/00000044", update, update_pc);
        else passed++;
        idle(1, 1);
    endtask

    task automatic test_mispredict;
        logic [1:0] tp [5];
        tp = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        test_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h3000 + 32'(i * 4), tp[i][1], tp[i][0], 0, 0, 0, 0, 1);
        idle(2, 1);
        total++;
        if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd3)
            $display("FAIL mispred_counts: got br=%0d mis=%0d expected 5/3", branch_cnt, mispred_cnt);
        else passed++;
    endtask

    task automatic test_reset_midop;
        test_reset();
        cycle(1, 32'h500, 0, 0, 1, 32'h504, 1, 0, 1);
        cycle(1, 32'h508, 1, 1, 1, 32'h50C, 0, 0, 1);
        total++;
        if (update !== 1'b1 || m_count != 3)
            $display("FAIL midop_setup: got upd=%b occ=%0d expected 1/3", update, m_count);
        else passed++;
        test_reset();
        idle(3, 1);
        total++;
        if (update !== 1'b0 || branch_cnt !== 32'd0)
            $display("FAIL midop_no_stale: got upd=%b br=%0d expected 0/0", update, branch_cnt);
        else passed++;
        cycle(1, 32'h600, 1, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (update !== 1'b1 || update_pc !== 32'h600)
            $display("FAIL midop_fresh: got upd=%b pc=%h expected 1/00000600", update, update_pc);
        else passed++;
        idle(1, 1);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        a_valid = 0; a_pc = 0; a_taken = 0; a_pred = 0;
        b_valid = 0; b_pc = 0; b_taken = 0; b_pred = 0;
        accepted_n = 0; issued_n = 0; b_drop_seen = 1'b0;
        test_reset();
        test_single();
        test_dual_order();
        test_back_to_back();
        test_stall();
        test_mispredict();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
